// File: rtl/ppu_spr_line.sv
// Per-scanline sprite renderer: the staging slots for the next line are copied to the active set at line_start.
// Each pixel step resolves the lowest-index opaque sprite and detects a sprite-0 hit.
module ppu_spr_line #(
    parameter int NUM_SPR = 8,
    parameter int SLOT_W  = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic              pix_en,
    input  logic              ld_en,
    input  logic [SLOT_W-1:0] ld_slot,
    input  logic [7:0]        ld_x,
    input  logic [7:0]        ld_attr,
    input  logic [7:0]        ld_low,
    input  logic [7:0]        ld_high,
    input  logic              ld_spr0,
    input  logic              bg_opaque,
    input  logic              clip_left,
    input  logic              hit_clr,
    output logic [3:0]        pixel,
    output logic              pix_behind,
    output logic              spr0_hit
);

    logic       stg_valid_q [NUM_SPR], stg_valid_d [NUM_SPR];
    logic       stg_spr0_q  [NUM_SPR], stg_spr0_d  [NUM_SPR];
    logic [7:0] stg_x_q     [NUM_SPR], stg_x_d     [NUM_SPR];
    logic [7:0] stg_attr_q  [NUM_SPR], stg_attr_d  [NUM_SPR];
    logic [7:0] stg_low_q   [NUM_SPR], stg_low_d   [NUM_SPR];
    logic [7:0] stg_high_q  [NUM_SPR], stg_high_d  [NUM_SPR];
    logic       act_valid_q [NUM_SPR], act_valid_d [NUM_SPR];
    logic       act_spr0_q  [NUM_SPR], act_spr0_d  [NUM_SPR];
    logic [7:0] act_x_q     [NUM_SPR], act_x_d     [NUM_SPR];
    logic [7:0] act_attr_q  [NUM_SPR], act_attr_d  [NUM_SPR];
    logic [7:0] act_low_q   [NUM_SPR], act_low_d   [NUM_SPR];
    logic [7:0] act_high_q  [NUM_SPR], act_high_d  [NUM_SPR];
    logic [3:0] act_cnt_q   [NUM_SPR], act_cnt_d   [NUM_SPR];
    logic [8:0] pcnt_q, pcnt_d;
    logic [3:0] pixel_q, pixel_d;
    logic       behind_q, behind_d;
    logic       hit_q, hit_d;

    logic       win_found, win_behind, spr0_src, visible, hit_set, ld_ok;
    logic [3:0] win_pix;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = v[7-b];
        return r;
    endfunction

    // Scan from the top slot down so the lowest-index opaque slot wins.
    always_comb begin
        win_found  = 1'b0;
        win_pix    = 4'd0;
        win_behind = 1'b0;
        spr0_src   = 1'b0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (act_valid_q[i] && act_x_q[i] == 8'd0 && !act_cnt_q[i][3] &&
                (act_high_q[i][7] || act_low_q[i][7])) begin
                win_found  = 1'b1;
                win_pix    = {act_attr_q[i][1:0], act_high_q[i][7], act_low_q[i][7]};
                win_behind = act_attr_q[i][5];
                if (act_spr0_q[i]) spr0_src = 1'b1;
            end
        end
    end

    assign visible = !(clip_left && pcnt_q < 9'd8) && pcnt_q != 9'd256;
    assign hit_set = spr0_src && bg_opaque && pcnt_q != 9'd255 && visible;
    assign ld_ok   = int'(ld_slot) < NUM_SPR;

    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_spr0_d  = stg_spr0_q;
        stg_x_d     = stg_x_q;
        stg_attr_d  = stg_attr_q;
        stg_low_d   = stg_low_q;
        stg_high_d  = stg_high_q;
        act_valid_d = act_valid_q;
        act_spr0_d  = act_spr0_q;
        act_x_d     = act_x_q;
        act_attr_d  = act_attr_q;
        act_low_d   = act_low_q;
        act_high_d  = act_high_q;
        act_cnt_d   = act_cnt_q;
        pcnt_d      = pcnt_q;
        pixel_d     = pixel_q;
        behind_d    = behind_q;
        hit_d       = hit_q;
        if (line_start) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                act_valid_d[i] = stg_valid_q[i];
                act_spr0_d[i]  = stg_spr0_q[i];
                act_x_d[i]     = stg_x_q[i];
                act_attr_d[i]  = stg_attr_q[i];
                act_low_d[i]   = stg_low_q[i];
                act_high_d[i]  = stg_high_q[i];
                act_cnt_d[i]   = 4'd0;
                stg_valid_d[i] = 1'b0;
            end
            pcnt_d = 9'd0;
        end else if (pix_en) begin
            pixel_d  = (visible && win_found) ? win_pix : 4'd0;
            behind_d = visible && win_found && win_behind;
            if (hit_set) hit_d = 1'b1;
            if (pcnt_q != 9'd256) pcnt_d = pcnt_q + 9'd1;
            for (int i = 0; i < NUM_SPR; i++) begin
                if (act_x_q[i] != 8'd0) begin
                    act_x_d[i] = act_x_q[i] - 8'd1;
                end else if (!act_cnt_q[i][3]) begin
                    act_low_d[i]  = {act_low_q[i][6:0], 1'b0};
                    act_high_d[i] = {act_high_q[i][6:0], 1'b0};
                    act_cnt_d[i]  = act_cnt_q[i] + 4'd1;
                end
            end
        end
        // Applied after the copy so a coincident load lands in staging for the next line.
        if (ld_en && ld_ok) begin
            stg_valid_d[ld_slot] = 1'b1;
            stg_spr0_d[ld_slot]  = ld_spr0;
            stg_x_d[ld_slot]     = ld_x;
            stg_attr_d[ld_slot]  = ld_attr;
            stg_low_d[ld_slot]   = ld_attr[6] ? rev8(ld_low) : ld_low;
            stg_high_d[ld_slot]  = ld_attr[6] ? rev8(ld_high) : ld_high;
        end
        if (hit_clr) hit_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                stg_valid_q[i] <= 1'b0;
                stg_spr0_q[i]  <= 1'b0;
                stg_x_q[i]     <= 8'd0;
                stg_attr_q[i]  <= 8'd0;
                stg_low_q[i]   <= 8'd0;
                stg_high_q[i]  <= 8'd0;
                act_valid_q[i] <= 1'b0;
                act_spr0_q[i]  <= 1'b0;
                act_x_q[i]     <= 8'd0;
                act_attr_q[i]  <= 8'd0;
                act_low_q[i]   <= 8'd0;
                act_high_q[i]  <= 8'd0;
                act_cnt_q[i]   <= 4'd0;
            end
            pcnt_q   <= 9'd0;
            pixel_q  <= 4'd0;
            behind_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_spr0_q  <= stg_spr0_d;
            stg_x_q     <= stg_x_d;
            stg_attr_q  <= stg_attr_d;
            stg_low_q   <= stg_low_d;
            stg_high_q  <= stg_high_d;
            act_valid_q <= act_valid_d;
            act_spr0_q  <= act_spr0_d;
            act_x_q     <= act_x_d;
            act_attr_q  <= act_attr_d;
            act_low_q   <= act_low_d;
            act_high_q  <= act_high_d;
            act_cnt_q   <= act_cnt_d;
            pcnt_q      <= pcnt_d;
            pixel_q     <= pixel_d;
            behind_q    <= behind_d;
            hit_q       <= hit_d;
        end
    end

    assign pixel      = pixel_q;
    assign pix_behind = behind_q;
    assign spr0_hit   = hit_q;

endmodule

// File: doc/ppu_spr_line.md
PPU_SPR_LINE -- requirements
Module: ppu_spr_line

Interface
REQ-001 SHALL have parameter NUM_SPR, default 8, legal range 1..64: number of sprite slots rendered per scanline.
REQ-002 SHALL have parameter SLOT_W, default $clog2(NUM_SPR) (minimum 1): slot-index width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 line_start  in  1  one-cycle pulse before the first visible pixel of a line.
REQ-006 pix_en  in  1  advance one pixel.
REQ-007 ld_en  in  1  write one staging slot.
REQ-008 ld_slot  in  SLOT_W  staging slot index.
REQ-009 ld_x, ld_attr, ld_low, ld_high  in  8 each  sprite X, attribute byte, pattern low plane, pattern high plane.
REQ-010 ld_spr0  in  1  slot holds OAM sprite 0.
REQ-011 bg_opaque  in  1  background pixel at current position is non-transparent.
REQ-012 clip_left  in  1  hide sprites in pixels 0..7.
REQ-013 hit_clr  in  1  clear spr0_hit.
REQ-014 pixel  out  4  {palette[1:0], high bit, low bit}.
REQ-015 pix_behind  out  1  winning sprite has attr[5] set.
REQ-016 spr0_hit  out  1  sticky sprite-0 hit flag.

Function
REQ-017 ld_en SHALL write ld_* into staging slot ld_slot and set that slot's valid bit; ld_slot >= NUM_SPR SHALL be ignored.
REQ-018 When ld_attr[6]=1, low and high planes SHALL be bit-reversed at load.
REQ-019 line_start SHALL copy all staging slots into the active set in one cycle, clear all staging valid bits, reset pixel counter pcnt (9 bits) to 0, and reset every slot's shift count to 0.
REQ-020 When ld_en and line_start coincide, the copy SHALL use the old staging contents, and the new load SHALL land in staging with valid=1.
REQ-021 On pix_en, per active slot: if x counter != 0, decrement it; else if shift count < 8, shift both planes left by 1 and increment shift count.
REQ-022 A slot SHALL be live when valid=1, x counter=0 and shift count<8; its pixel is {high[7], low[7]}; it is opaque when that pair != 0.
REQ-023 The winner SHALL be the lowest-index live opaque slot; if none, output SHALL be transparent (pixel=0, pix_behind=0).
REQ-024 When clip_left=1 and pcnt<8, output SHALL be transparent, and no sprite-0 hit SHALL be set.
REQ-025 pixel and pix_behind SHALL be registered, updated on pix_en, and reflect the position pcnt held before that edge (1-cycle latency); they hold when pix_en=0.
REQ-026 pcnt SHALL increment on pix_en, saturate at 256, and output transparent at 256.
REQ-027 spr0_hit SHALL set on pix_en when the spr0-flagged slot is live and opaque, bg_opaque=1, pcnt != 255, and the pixel is not clipped; the hit is independent of priority.
REQ-028 hit_clr SHALL clear spr0_hit and SHALL win over a same-cycle set.
REQ-029 line_start and pix_en in the same cycle SHALL perform line_start only.

Reset
REQ-030 While reset_n=0: all staging and active valid bits=0, pcnt=0, pixel=0, pix_behind=0, spr0_hit=0; deassertion mid-line requires line_start before valid output.

Verification
REQ-031 Slot 3: x=5, low=0x80, high=0x00, attr=0x01; line_start; 8 pix_en -> pixel=4'b0101 only for pcnt=5, else 0.
REQ-032 Slots 0 and 1 both x=10, opaque, different palettes -> slot 0's palette at pcnt=10; make slot 0 transparent -> slot 1 shown.
REQ-033 attr[6]=1, low=0x01, x=0 -> opaque at pcnt=0 only; clip_left=1 -> transparent at pcnt=0.
REQ-034 spr0 slot at x=255 with bg_opaque=1 -> spr0_hit stays 0; at x=20 -> spr0_hit=1 after pcnt=20 edge; hit_clr with coincident hit -> 0.
REQ-035 ld_en to slot 2 coincident with line_start -> current line excludes it, next line renders it; reset_n low mid-line -> all outputs 0 immediately.
